// File: rtl/ctrl_psum_packer_pkg.sv
// Shared constants and types for the controller result path (packer and result reverser).
// Lane geometry, fill-buffer state encoding and the lane-placement rule live here.
package ctrl_psum_packer_pkg;

  localparam int PARTIAL_SUM_BW = 20;
  localparam int WORDSIZE       = 160;
  localparam int LANES          = WORDSIZE / PARTIAL_SUM_BW;
  localparam int OUT_COUNT_W    = $clog2(LANES + 1);
  localparam int IDX_W          = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } psum_fill_state_e;

  // Physical lane for beat number idx; reversed order puts the first beat in the MSB lane.
  function automatic int lane_of(input int idx, input logic rev, input int lanes);
    return rev ? (lanes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/ctrl_psum_packer_lane_writer.sv
// Combinational lane insert: returns the fill word with one lane replaced by the beat data.
// All other lanes pass through untouched.
module CTRL_psum_lane_writer
  import ctrl_psum_packer_pkg::*;
#(
  parameter int WORDSIZE       = ctrl_psum_packer_pkg::WORDSIZE,
  parameter int PARTIAL_SUM_BW = ctrl_psum_packer_pkg::PARTIAL_SUM_BW,
  parameter int IDX_W          = ctrl_psum_packer_pkg::IDX_W
) (
  input  logic [WORDSIZE-1:0]              fill_i,
  input  logic signed [PARTIAL_SUM_BW-1:0] data_i,
  input  logic [IDX_W-1:0]                 idx_i,
  input  logic                             rev_i,
  output logic [WORDSIZE-1:0]              fill_o
);

  localparam int NUM_LANES = WORDSIZE / PARTIAL_SUM_BW;

  int lane_sel;

  always_comb begin
    lane_sel = lane_of(int'(idx_i), rev_i, NUM_LANES);
    fill_o   = fill_i;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (l == lane_sel) begin
        fill_o[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = data_i;
      end
    end
  end

endmodule

// File: rtl/ctrl_psum_packer.sv
// Packs a stream of signed partial sums into LANES-wide result words.
// A fill buffer, a one-word holding slot and a registered output port sustain one beat per cycle.
module ctrl_psum_packer
  import ctrl_psum_packer_pkg::*;
#(
  parameter int WORDSIZE       = ctrl_psum_packer_pkg::WORDSIZE,
  parameter int PARTIAL_SUM_BW = ctrl_psum_packer_pkg::PARTIAL_SUM_BW,
  localparam int NUM_LANES     = WORDSIZE / PARTIAL_SUM_BW,
  localparam int CNT_W         = $clog2(NUM_LANES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [PARTIAL_SUM_BW-1:0] in_data,
  input  logic                             in_last,
  input  logic                             reverse,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORDSIZE-1:0]              out_data,
  output logic [CNT_W-1:0]                 out_count
);

  localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  psum_fill_state_e    state_q, state_d;
  logic [LIDX_W-1:0]   idx_q, idx_d;
  logic                rev_q, rev_d;
  logic [WORDSIZE-1:0] fill_q, fill_d;
  logic [WORDSIZE-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [WORDSIZE-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic                complete;
  logic                out_free;
  logic                rev_eff;
  logic [CNT_W-1:0]    cnt_new;
  logic [WORDSIZE-1:0] fill_wr;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = !rst && (state_q != HOLD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // The first beat of a word sees the live reverse input; later beats use the latched order.
  assign rev_eff = (idx_q == '0) ? reverse : rev_q;

  CTRL_psum_lane_writer #(
    .WORDSIZE       (WORDSIZE),
    .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
    .IDX_W          (LIDX_W)
  ) u_lane_writer (
    .fill_i (fill_q),
    .data_i (in_data),
    .idx_i  (idx_q),
    .rev_i  (rev_eff),
    .fill_o (fill_wr)
  );

  always_comb begin
    accept   = in_valid && in_ready;
    out_free = !out_valid_q || out_ready;
    complete = accept && ((idx_q == LIDX_W'(NUM_LANES - 1)) || in_last);
    cnt_new  = CNT_W'(idx_q) + CNT_W'(1);

    state_d     = state_q;
    idx_d       = idx_q;
    rev_d       = rev_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q && !out_ready;

    unique case (state_q)
      EMPTY, FILL: begin
        if (accept) begin
          rev_d = rev_eff;
          if (!complete) begin
            fill_d  = fill_wr;
            idx_d   = idx_q + LIDX_W'(1);
            state_d = FILL;
          end else if (out_free) begin
            out_data_d  = fill_wr;
            out_count_d = cnt_new;
            out_valid_d = 1'b1;
            fill_d      = '0;
            idx_d       = '0;
            state_d     = EMPTY;
          end else begin
            hold_d     = fill_wr;
            hold_cnt_d = cnt_new;
            fill_d     = '0;
            idx_d      = '0;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        // Output register is occupied here, so out_ready alone frees it this edge.
        if (out_ready) begin
          out_data_d  = hold_q;
          out_count_d = hold_cnt_q;
          out_valid_d = 1'b1;
          hold_d      = '0;
          hold_cnt_d  = '0;
          state_d     = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      rev_q       <= 1'b0;
      fill_q      <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rev_q       <= rev_d;
      fill_q      <= fill_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/ctrl_psum_packer.md
# ctrl_psum_packer

Stream-to-word packer for the controller's result path. It accepts one signed partial sum per valid/ready beat from the accumulator column stream and assembles `LANES` of them into one packed result word. Lane order is selectable: natural order, or reversed so that the first beat lands in the MSB lane. Completed words leave on a registered valid/ready port into the result reverser and writeback path. A fill buffer plus an output register give a double buffer, so sustained throughput is one beat per cycle.

## Interface
Parameters:
- `WORDSIZE`, 160: packed output word width in bits.
- `PARTIAL_SUM_BW`, 20: width of one partial sum (one lane).
- `LANES`, `WORDSIZE/PARTIAL_SUM_BW` (8): derived, not overridden. `WORDSIZE` must be an exact multiple of `PARTIAL_SUM_BW`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset; synchronous and active-high.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: packer can accept a beat.
- `in_data`, in, `PARTIAL_SUM_BW`: partial sum value.
- `in_last`, in, 1: this beat closes the word early; unfilled lanes are zero.
- `reverse`, in, 1: lane-order select, sampled on the first beat of each word.
- `out_valid`, out, 1: packed word available.
- `out_ready`, in, 1: downstream accepts the word.
- `out_data`, out, `WORDSIZE`: packed word.
- `out_count`, out, `$clog2(LANES+1)`: number of lanes written in `out_data` (1..`LANES`).

## Operation
- Beat accepted when `in_valid && in_ready`. Word handshake completes when `out_valid && out_ready`.
- Lane index `idx` counts accepted beats within the current word, from 0 to `LANES-1`.
- Lane placement:
  - `rev_q = 0`: beat `idx` goes to bits `[idx*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]`.
  - `rev_q = 1`: beat `idx` goes to lane `LANES-1-idx`.
- `rev_q` is latched from `reverse` on the beat with `idx == 0`. Changes to `reverse` during a word have no effect.
- Word completion: the accepted beat has `idx == LANES-1`, or `in_last == 1`. After completion, `idx` returns to 0 and the fill buffer is cleared to zero.
- Fill-buffer FSM:
  - `EMPTY`: `idx == 0`, no beats held.
  - `FILL`: 1 to `LANES-1` beats held.
  - `HOLD`: a complete word is waiting for the output register.
- FSM transitions:
  - `EMPTY`/`FILL` to `FILL`: a beat is accepted and the word is not complete.
  - To `EMPTY` (transfer): the word completes and the output register is free this cycle, i.e. `!out_valid || out_ready`. The output register loads the assembled word, including the current beat.
  - To `HOLD`: the word completes and the output register is not free.
  - `HOLD` to `EMPTY`: `out_ready` is high. The held word moves to the output register in the same edge.
- `in_ready = !rst && (state != HOLD)`. There is no combinational path from `out_ready` to `in_ready`; a draining cycle in `HOLD` still shows `in_ready = 0`.
- `out_count` is the number of beats in the transferred word.
- Data is carried unmodified. No sign extension, saturation or arithmetic is applied.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_count = 0`, FSM `EMPTY`, `idx = 0`, `rev_q = 0`, fill buffer zero. `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Latency: final beat accepted at cycle t with the output register free gives `out_valid = 1` at t+1.
- Leaving `HOLD`: `out_ready` high at cycle t gives the new word on the outputs at t+1. `in_ready` reaches 1 at t+1.
- Throughput: with `out_ready` held high, back-to-back words are accepted with zero bubbles.
- `out_data`, `out_count` and `out_valid` stay stable while `out_valid && !out_ready`.
- `in_last` on the beat with `idx == LANES-1` is a normal full word with `out_count = LANES`.
- `rst` asserted mid-word or mid-`HOLD` discards all held data. No partial word is emitted.
- Beats presented while `in_ready = 0` are ignored; the source must hold them.

## Structure
- Shared package holds `PARTIAL_SUM_BW`, `WORDSIZE`, `LANES`, the FSM state enum (`EMPTY`, `FILL`, `HOLD`) and the `out_count` width constant. The package is shared with the result reverser.
- One natural sub-module, `CTRL_psum_lane_writer`: combinational. It takes the fill word, beat data, `idx` and `rev_q`, and produces the next fill word with the one lane replaced.
- Top level holds the FSM, `idx` counter, `rev_q`, fill buffer and output register.

## Test plan
- 8 beats with values 1..8, `reverse = 0`, `out_ready = 1`: expect `out_data` lane0 = 1 … lane7 = 8, `out_count = 8`, `out_valid` one cycle after beat 8.
- Same 8 beats with `reverse = 1`, and `reverse` toggled at beat 4: expect lane7 = 1 … lane0 = 8; the toggle is ignored.
- 3 beats (`0xFFFFF`, 2, 3) with `in_last` on beat 3: expect lanes 0..2 = `0xFFFFF`, 2, 3, lanes 3..7 = 0, `out_count = 3`.
- `out_ready = 0`, 16 beats offered continuously: expect word A on the output, word B in `HOLD`, and `in_ready = 0` after beat 16. Raise `out_ready` for 1 cycle: expect B on the output next cycle and `in_ready = 1`.
- 4 words streamed with `out_ready = 1`: expect 32 consecutive accepted beats, with `out_valid` pulsing every 8 cycles.
- `rst` pulsed after 5 beats: expect all outputs 0 the next cycle. The next 8 beats produce a clean word with no residue from the discarded partial word.
